// File: rtl/ldl_fifo_pkg.sv
// Shared FIFO definitions: read-mode constants and depth helper for the ldl FIFO family.
package ldl_fifo_pkg;

  localparam int LDL_FIFO_NORMAL = 0;
  localparam int LDL_FIFO_AHEAD  = 1;

  function automatic int ldl_fifo_depth(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/ldl_sfifo_v2_ram.sv
// DW x 2**AW register array: one synchronous write port, one asynchronous read port.
module ldl_sfifo_v2_ram
  import ldl_fifo_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] din,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [ldl_fifo_depth(AW)];

  // Contents are intentionally not reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= din;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ldl_sfifo_v2.sv
// Single-clock FIFO with word count, almost-full/empty thresholds and show-ahead or registered read.
// Optional sticky overflow/underflow flags are built when LDL_SFIFO_V2_ERR_EN is defined.
module ldl_sfifo_v2
  import ldl_fifo_pkg::*;
#(
  parameter int DW    = 8,
  parameter int AW    = 4,
  parameter int AHEAD = LDL_FIFO_AHEAD,
  parameter int AF_TH = ldl_fifo_depth(AW) - 2,
  parameter int AE_TH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [DW-1:0] din,
  input  logic          re,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic          afull,
  output logic          aempty,
  output logic [AW:0]   cnt,
  output logic          ovf,
  output logic          udf
);

  localparam int          DEPTH    = ldl_fifo_depth(AW);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
  localparam logic [AW:0] AF_CNT   = AF_TH[AW:0];
  localparam logic [AW:0] AE_CNT   = AE_TH[AW:0];

  if (!(AE_TH >= 0 && AE_TH < AF_TH && AF_TH <= DEPTH)) begin : g_bad_thresholds
    $error("ldl_sfifo_v2: thresholds must satisfy AE_TH < AF_TH <= 2**AW");
  end
  if (AHEAD != LDL_FIFO_AHEAD && AHEAD != LDL_FIFO_NORMAL) begin : g_bad_mode
    $error("ldl_sfifo_v2: AHEAD must be 0 or 1");
  end

  logic [AW:0]   wr_ptr, rd_ptr, cnt_q;
  logic          wr_acc, rd_acc;
  logic [DW-1:0] rd_data;

  // Handshake: we/re are requests; a write is taken when we && !full, a read when
  // re && !empty. Rejected requests leave data, pointers and count untouched.
  assign full   = (cnt_q == FULL_CNT);
  assign empty  = (cnt_q == '0);
  assign afull  = (cnt_q >= AF_CNT);
  assign aempty = (cnt_q <= AE_CNT);
  assign cnt    = cnt_q;
  assign wr_acc = we && !full;
  assign rd_acc = re && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  ldl_sfifo_v2_ram #(.DW(DW), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr[AW-1:0]),
    .din   (din),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rd_data)
  );

  if (AHEAD == LDL_FIFO_AHEAD) begin : g_ahead
    assign dout = rd_data;
  end else begin : g_normal
    logic [DW-1:0] dout_q;
    always_ff @(posedge clk) begin
      if (rst)         dout_q <= '0;
      else if (rd_acc) dout_q <= rd_data;
    end
    assign dout = dout_q;
  end

`ifdef LDL_SFIFO_V2_ERR_EN
  logic ovf_q, udf_q;
  // Flags trigger on the request against the current state, independent of the other port.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (we && full)  ovf_q <= 1'b1;
      if (re && empty) udf_q <= 1'b1;
    end
  end
  assign ovf = ovf_q;
  assign udf = udf_q;
`else
  assign ovf = 1'b0;
  assign udf = 1'b0;
`endif

endmodule

// File: tb/tb_ldl_sfifo_v2.sv
// Directed bench for ldl_sfifo_v2: show-ahead and normal-mode instances driven in lockstep.
module tb_ldl_sfifo_v2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       we  = 1'b0;
  logic       re  = 1'b0;
  logic [7:0] din = 8'h00;

  logic [7:0] a_dout, n_dout;
  logic       a_full, a_empty, a_afull, a_aempty, a_ovf, a_udf;
  logic       n_full, n_empty, n_afull, n_aempty, n_ovf, n_udf;
  logic [4:0] a_cnt, n_cnt;

`ifdef LDL_SFIFO_V2_ERR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  int         tests = 0;
  int         failed = 0;
  int         m_cnt = 0;
  logic [7:0] exp_q[$];

  ldl_sfifo_v2 #(.DW(8), .AW(4), .AHEAD(1), .AF_TH(14), .AE_TH(2)) u_ahead (
    .clk(clk), .rst(rst), .we(we), .din(din), .re(re), .dout(a_dout),
    .full(a_full), .empty(a_empty), .afull(a_afull), .aempty(a_aempty),
    .cnt(a_cnt), .ovf(a_ovf), .udf(a_udf)
  );

  ldl_sfifo_v2 #(.DW(8), .AW(4), .AHEAD(0), .AF_TH(14), .AE_TH(2)) u_norm (
    .clk(clk), .rst(rst), .we(we), .din(din), .re(re), .dout(n_dout),
    .full(n_full), .empty(n_empty), .afull(n_afull), .aempty(n_aempty),
    .cnt(n_cnt), .ovf(n_ovf), .udf(n_udf)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    we  = 1'b0;
    re  = 1'b0;
    tick();
    rst = 1'b0;
    exp_q.delete();
    m_cnt = 0;
  endtask

  // One clock of stimulus; the queue predicts what each accepted read returns.
  task automatic cycle(input logic w, input logic [7:0] d, input logic r);
    logic       wa, ra;
    logic [7:0] popped;
    wa = w && (m_cnt != 16);
    ra = r && (m_cnt != 0);
    popped = 8'h00;
    if (ra) begin
      check("ahead_dout", a_dout, exp_q[0]);
      popped = exp_q.pop_front();
    end
    if (wa) exp_q.push_back(d);
    we = w; din = d; re = r;
    tick();
    m_cnt = m_cnt + (wa ? 1 : 0) - (ra ? 1 : 0);
    if (ra) check("norm_dout", n_dout, popped);
    we = 1'b0; re = 1'b0;
  endtask

  initial begin
    // Reset state
    tick();
    reset_dut();
    check("rst_cnt", a_cnt, 0);
    check("rst_empty", a_empty, 1);
    check("rst_full", a_full, 0);
    check("rst_aempty", a_aempty, 1);
    check("rst_afull", a_afull, 0);
    check("rst_ovf", a_ovf, 0);
    check("rst_udf", a_udf, 0);
    check("rst_norm_dout", n_dout, 8'h00);

    // Read from empty
    cycle(1'b0, 8'h00, 1'b1);
    check("udf_cnt", a_cnt, 0);
    check("udf_empty", n_empty, 1);
    check("udf_norm_dout", n_dout, 8'h00);
    check("udf_flag", a_udf, EXP_ERR);
    check("udf_flag_n", n_udf, EXP_ERR);

    // Write A1..A4
    reset_dut();
    check("udf_cleared", a_udf, 0);
    cycle(1'b1, 8'hA1, 1'b0);
    check("w1_empty", a_empty, 0);
    check("w1_ahead_dout", a_dout, 8'hA1);
    cycle(1'b1, 8'hA2, 1'b0);
    check("w2_aempty", a_aempty, 1);
    cycle(1'b1, 8'hA3, 1'b0);
    check("w3_aempty", a_aempty, 0);
    cycle(1'b1, 8'hA4, 1'b0);
    check("w4_cnt", a_cnt, 4);
    check("w4_ahead_dout", a_dout, 8'hA1);

    // Fill to 16, thresholds, overflow
    for (int i = 0; i < 9; i++) cycle(1'b1, 8'hB0 + 8'(i), 1'b0);
    check("c13_cnt", a_cnt, 13);
    check("c13_afull", a_afull, 0);
    cycle(1'b1, 8'hB9, 1'b0);
    check("c14_afull", a_afull, 1);
    check("c14_full", a_full, 0);
    cycle(1'b1, 8'hBA, 1'b0);
    cycle(1'b1, 8'hBB, 1'b0);
    check("c16_full", a_full, 1);
    check("c16_cnt", n_cnt, 16);
    check("c16_ovf_pre", a_ovf, 0);
    cycle(1'b1, 8'hEE, 1'b0);
    check("ovf_cnt", a_cnt, 16);
    check("ovf_flag", a_ovf, EXP_ERR);
    check("ovf_flag_n", n_ovf, EXP_ERR);

    // Read+write while full: only the read is taken, then a write fits
    cycle(1'b1, 8'hCC, 1'b1);
    check("rwfull_cnt", a_cnt, 15);
    check("rwfull_full", a_full, 0);
    check("rwfull_dout", n_dout, 8'hA1);
    cycle(1'b1, 8'hDD, 1'b0);
    check("refill_full", a_full, 1);

    // Drain in order
    for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b1);
    check("drain_cnt", a_cnt, 0);
    check("drain_empty", a_empty, 1);
    check("drain_last", n_dout, 8'hDD);
    check("drain_ovf_sticky", a_ovf, EXP_ERR);

    // Pointer wrap with simultaneous read/write at cnt=5
    reset_dut();
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'h30 + 8'(i), 1'b0);
    for (int i = 0; i < 40; i++) cycle(1'b1, 8'h40 + 8'(i), 1'b1);
    check("wrap_cnt", a_cnt, 5);
    check("wrap_cnt_n", n_cnt, 5);
    check("wrap_last", n_dout, 8'h40 + 8'd34);

    // Reset mid-operation at cnt=9
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'h60 + 8'(i), 1'b0);
    check("pre_rst_cnt", a_cnt, 9);
    reset_dut();
    check("mrst_cnt", a_cnt, 0);
    check("mrst_empty", a_empty, 1);
    check("mrst_full", a_full, 0);
    check("mrst_ovf", a_ovf, 0);
    check("mrst_udf", a_udf, 0);
    check("mrst_norm_dout", n_dout, 8'h00);
    cycle(1'b1, 8'h5A, 1'b0);
    check("mrst_first_ahead", a_dout, 8'h5A);
    cycle(1'b0, 8'h00, 1'b1);
    check("mrst_first_norm", n_dout, 8'h5A);

    // Normal-mode read latency
    cycle(1'b1, 8'h11, 1'b0);
    cycle(1'b1, 8'h22, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    check("norm_rd1", n_dout, 8'h11);
    cycle(1'b0, 8'h00, 1'b1);
    check("norm_rd2", n_dout, 8'h22);
    cycle(1'b0, 8'h00, 1'b0);
    check("norm_hold", n_dout, 8'h22);
    check("final_empty", n_empty, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
